// File: rtl/weighted_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// weighted_rr_arbiter_if
//
// Purpose: groups the request, quantum-configuration and grant signals of
// the weighted round-robin arbiter into one bundle.
//
// Signals:
//   REQ[3:0]       request per requester, level-held while service is wanted
//   CFG_WE         quantum write strobe
//   CFG_ADDR[1:0]  requester index of the quantum write
//   CFG_Q[QW-1:0]  quantum value, in grant cycles
//   GNT[3:0]       one-hot grant, all-zero when idle
//   GNT_ID[1:0]    index of the current owner, 0 when idle
//   GNT_VLD        high whenever GNT is non-zero
//   SLICE_END      high in the final cycle of the owner's quantum
//
// Modports:
//   master  requesters / configuration side (drives REQ and CFG_*)
//   slave   arbiter side (drives the grant outputs)
// ---------------------------------------------------------------------------
interface weighted_rr_arbiter_if #(
   parameter int QW = 4
);

   logic [3:0]    REQ;
   logic          CFG_WE;
   logic [1:0]    CFG_ADDR;
   logic [QW-1:0] CFG_Q;
   logic [3:0]    GNT;
   logic [1:0]    GNT_ID;
   logic          GNT_VLD;
   logic          SLICE_END;

   modport master (
      output REQ,
      output CFG_WE,
      output CFG_ADDR,
      output CFG_Q,
      input  GNT,
      input  GNT_ID,
      input  GNT_VLD,
      input  SLICE_END
   );

   modport slave (
      input  REQ,
      input  CFG_WE,
      input  CFG_ADDR,
      input  CFG_Q,
      output GNT,
      output GNT_ID,
      output GNT_VLD,
      output SLICE_END
   );

endinterface

// File: rtl/weighted_rr_arbiter.sv
// ---------------------------------------------------------------------------
// weighted_rr_arbiter
//
// Purpose: four-requester round-robin arbiter in which every requester owns
// the grant for a programmable number of consecutive cycles (its quantum)
// before the grant rotates. A requester that drops its request releases the
// grant immediately, and the next requester is granted in the very next
// cycle, so there are no dead cycles between owners.
//
// Ports:
//   clk   single clock, all state updates on the rising edge
//   rst   asynchronous, active-high reset
//   bus   weighted_rr_arbiter_if.slave:
//           REQ, CFG_WE, CFG_ADDR, CFG_Q  (inputs)
//           GNT, GNT_ID, GNT_VLD, SLICE_END (outputs)
//
// Parameters:
//   QW         width of each quantum register and of the slice counter
//   DEFAULT_Q  reset value of every quantum register
// ---------------------------------------------------------------------------
module weighted_rr_arbiter #(
   parameter int QW        = 4,
   parameter int DEFAULT_Q = 2
) (
   input logic                 clk,
   input logic                 rst,
   weighted_rr_arbiter_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [QW-1:0] CNT_ONE  = {{(QW-1){1'b0}}, 1'b1};
   localparam logic [QW-1:0] CNT_MAX  = {QW{1'b1}};
   localparam logic [QW-1:0] Q_RESET  = QW'(DEFAULT_Q);

   state_t        state;
   logic [1:0]    owner;
   logic [1:0]    ptr;
   logic [QW-1:0] cnt;
   logic [QW-1:0] q [4];
   logic [3:0]    gnt;
   logic [1:0]    gnt_id;

   logic [QW-1:0] eq;
   logic          slice_done;
   logic          owner_req;
   logic          idle_found;
   logic [1:0]    idle_idx;
   logic          busy_found;
   logic [1:0]    busy_idx;

   // Rotating priority search: examines n positions starting at 'start'
   // (mod 4) and returns {found, index} of the first set request bit.
   function automatic logic [2:0] find_next(
      input logic [3:0] req,
      input logic [1:0] start,
      input int         n
   );
      logic       found;
      logic [1:0] sel;
      logic [1:0] idx;
      found = 1'b0;
      sel   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         idx = start + 2'(i);
         if (!found && (i < n) && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      return {found, sel};
   endfunction

   // Decision inputs for the state register. A stored quantum of zero is
   // treated as one, so a zero-programmed requester still gets one cycle.
   // The idle search starts at ptr and covers all four requesters; the busy
   // search only looks at the three requesters after the current owner.
   always_comb begin
      eq         = (q[owner] == '0) ? CNT_ONE : q[owner];
      slice_done = (cnt >= eq);
      owner_req  = bus.REQ[owner];
      {idle_found, idle_idx} = find_next(bus.REQ, ptr, 4);
      {busy_found, busy_idx} = find_next(bus.REQ, owner + 2'd1, 3);
   end

   // Arbitration FSM plus quantum register file. The quantum write is
   // independent of the arbitration decision: a write on the same edge as a
   // decision does not influence that decision, only the next compare.
   // Because the compare is ">=", lowering the owner's quantum below the
   // current count ends the slice at the next compare rather than letting
   // the counter run on. The counter saturates instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         owner  <= 2'd0;
         ptr    <= 2'd0;
         cnt    <= '0;
         gnt    <= 4'b0000;
         gnt_id <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            q[i] <= Q_RESET;
         end
      end else begin
         if (bus.CFG_WE) begin
            q[bus.CFG_ADDR] <= bus.CFG_Q;
         end

         case (state)
            IDLE: begin
               if (idle_found) begin
                  state  <= BUSY;
                  owner  <= idle_idx;
                  cnt    <= CNT_ONE;
                  gnt    <= 4'b0001 << idle_idx;
                  gnt_id <= idle_idx;
               end
            end

            BUSY: begin
               if (owner_req && !slice_done) begin
                  if (cnt != CNT_MAX) begin
                     cnt <= cnt + CNT_ONE;
                  end
               end else if (busy_found) begin
                  owner  <= busy_idx;
                  ptr    <= owner + 2'd1;
                  cnt    <= CNT_ONE;
                  gnt    <= 4'b0001 << busy_idx;
                  gnt_id <= busy_idx;
               end else if (owner_req) begin
                  cnt <= CNT_ONE;
               end else begin
                  state  <= IDLE;
                  ptr    <= owner + 2'd1;
                  cnt    <= '0;
                  gnt    <= 4'b0000;
                  gnt_id <= 2'd0;
               end
            end

            default: begin
               state  <= IDLE;
               gnt    <= 4'b0000;
               gnt_id <= 2'd0;
            end
         endcase
      end
   end

   // SLICE_END looks at the live request so that an owner that has already
   // dropped its request is not reported as finishing a full quantum.
   always_comb begin
      bus.GNT       = gnt;
      bus.GNT_ID    = gnt_id;
      bus.GNT_VLD   = |gnt;
      bus.SLICE_END = (state == BUSY) && owner_req && slice_done;
   end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_weighted_rr_arbiter
//
// Purpose: directed, self-checking bench for weighted_rr_arbiter. Inputs are
// driven on the falling edge; outputs are sampled 1 time unit later, so each
// expected value describes the cycle in which those inputs are applied.
// ---------------------------------------------------------------------------
module tb_weighted_rr_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   weighted_rr_arbiter_if #(.QW(4)) bus ();

   weighted_rr_arbiter #(
      .QW        (4),
      .DEFAULT_Q (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       we;
      logic [1:0] addr;
      logic [3:0] qv;
      logic [3:0] exp_gnt;
      logic [1:0] exp_id;
      logic       exp_se;
   } vec_t;

   vec_t vecs [24];

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one cycle's inputs at the falling edge and lets them settle.
   task automatic applyStimulus(
      input logic       r,
      input logic [3:0] req,
      input logic       we,
      input logic [1:0] addr,
      input logic [3:0] qv
   );
      @(negedge clk);
      rst          = r;
      bus.REQ      = req;
      bus.CFG_WE   = we;
      bus.CFG_ADDR = addr;
      bus.CFG_Q    = qv;
      #1;
   endtask

   // Compares every output of the current cycle with the expectation.
   task automatic checkOutput(
      input string      name,
      input logic [3:0] exp_gnt,
      input logic [1:0] exp_id,
      input logic       exp_se
   );
      logic exp_vld;
      exp_vld = (exp_gnt != 4'b0000);
      checks += 4;
      if (bus.GNT !== exp_gnt) begin
         errors++;
         $display("[TB] FAIL %s GNT: got %b expected %b", name, bus.GNT, exp_gnt);
      end
      if (bus.GNT_ID !== exp_id) begin
         errors++;
         $display("[TB] FAIL %s GNT_ID: got %0d expected %0d", name, bus.GNT_ID, exp_id);
      end
      if (bus.GNT_VLD !== exp_vld) begin
         errors++;
         $display("[TB] FAIL %s GNT_VLD: got %b expected %b", name, bus.GNT_VLD, exp_vld);
      end
      if (bus.SLICE_END !== exp_se) begin
         errors++;
         $display("[TB] FAIL %s SLICE_END: got %b expected %b", name, bus.SLICE_END, exp_se);
      end
   endtask

   task automatic checkValue(
      input string name,
      input int    got,
      input int    exp
   );
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      bus.REQ      = 4'b0000;
      bus.CFG_WE   = 1'b0;
      bus.CFG_ADDR = 2'd0;
      bus.CFG_Q    = 4'd0;

      // rst, req, we, addr, q, exp_gnt, exp_id, exp_se
      // Two requesters with default quantum 2 alternate in pairs.
      vecs[0]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 4'd0, 4'b0000, 2'd0, 1'b0};
      vecs[1]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 4'b0000, 2'd0, 1'b0};
      vecs[2]  = '{1'b0, 4'b0101, 1'b0, 2'd0, 4'd0, 4'b0000, 2'd0, 1'b0};
      vecs[3]  = '{1'b0, 4'b0101, 1'b0, 2'd0, 4'd0, 4'b0001, 2'd0, 1'b0};
      vecs[4]  = '{1'b0, 4'b0101, 1'b0, 2'd0, 4'd0, 4'b0001, 2'd0, 1'b1};
      vecs[5]  = '{1'b0, 4'b0101, 1'b0, 2'd0, 4'd0, 4'b0100, 2'd2, 1'b0};
      vecs[6]  = '{1'b0, 4'b0101, 1'b0, 2'd0, 4'd0, 4'b0100, 2'd2, 1'b1};
      vecs[7]  = '{1'b0, 4'b0101, 1'b0, 2'd0, 4'd0, 4'b0001, 2'd0, 1'b0};
      vecs[8]  = '{1'b0, 4'b0101, 1'b0, 2'd0, 4'd0, 4'b0001, 2'd0, 1'b1};
      vecs[9]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 4'b0100, 2'd2, 1'b0};
      vecs[10] = '{1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 4'b0000, 2'd0, 1'b0};
      // q[2]=0 acts as 1; ptr is 3 after the release above, so 1 wins first.
      vecs[11] = '{1'b0, 4'b0000, 1'b1, 2'd2, 4'd0, 4'b0000, 2'd0, 1'b0};
      vecs[12] = '{1'b0, 4'b0110, 1'b0, 2'd0, 4'd0, 4'b0000, 2'd0, 1'b0};
      vecs[13] = '{1'b0, 4'b0110, 1'b0, 2'd0, 4'd0, 4'b0010, 2'd1, 1'b0};
      vecs[14] = '{1'b0, 4'b0110, 1'b0, 2'd0, 4'd0, 4'b0010, 2'd1, 1'b1};
      vecs[15] = '{1'b0, 4'b0110, 1'b0, 2'd0, 4'd0, 4'b0100, 2'd2, 1'b1};
      vecs[16] = '{1'b0, 4'b0110, 1'b0, 2'd0, 4'd0, 4'b0010, 2'd1, 1'b0};
      // Write q[1]=3 on the same edge as the hand-off decision.
      vecs[17] = '{1'b0, 4'b0110, 1'b1, 2'd1, 4'd3, 4'b0010, 2'd1, 1'b1};
      vecs[18] = '{1'b0, 4'b0110, 1'b0, 2'd0, 4'd0, 4'b0100, 2'd2, 1'b1};
      vecs[19] = '{1'b0, 4'b0110, 1'b0, 2'd0, 4'd0, 4'b0010, 2'd1, 1'b0};
      vecs[20] = '{1'b0, 4'b0110, 1'b0, 2'd0, 4'd0, 4'b0010, 2'd1, 1'b0};
      vecs[21] = '{1'b0, 4'b0110, 1'b0, 2'd0, 4'd0, 4'b0010, 2'd1, 1'b1};
      vecs[22] = '{1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 4'b0100, 2'd2, 1'b0};
      vecs[23] = '{1'b0, 4'b0000, 1'b0, 2'd0, 4'd0, 4'b0000, 2'd0, 1'b0};

      for (int i = 0; i < 24; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].qv);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_id, vecs[i].exp_se);
      end

      // Single requester with q[1]=5 keeps the grant; SLICE_END every 5th cycle.
      applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0, 4'd0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 2'd1, 4'd5);
      applyStimulus(1'b0, 4'b0010, 1'b0, 2'd0, 4'd0);
      checkOutput("q5_idle", 4'b0000, 2'd0, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(1'b0, 4'b0010, 1'b0, 2'd0, 4'd0);
         checkOutput($sformatf("q5_cyc%0d", k), 4'b0010, 2'd1, (k % 5) == 0);
      end

      // Owner 0 drops its request after one grant cycle: 3 takes over at once.
      applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0, 4'd0);
      applyStimulus(1'b0, 4'b1001, 1'b0, 2'd0, 4'd0);
      checkOutput("drop_idle", 4'b0000, 2'd0, 1'b0);
      applyStimulus(1'b0, 4'b1001, 1'b0, 2'd0, 4'd0);
      checkOutput("drop_own0", 4'b0001, 2'd0, 1'b0);
      applyStimulus(1'b0, 4'b1000, 1'b0, 2'd0, 4'd0);
      checkOutput("drop_released", 4'b0001, 2'd0, 1'b0);
      applyStimulus(1'b0, 4'b1000, 1'b0, 2'd0, 4'd0);
      checkOutput("drop_own3", 4'b1000, 2'd3, 1'b0);
      checkValue("drop_cnt", int'(dut.cnt), 1);
      checkValue("drop_ptr", int'(dut.ptr), 1);

      // Owner 3 with q[3]=4; q[3] lowered to 1 so the slice ends at cnt=3.
      applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0, 4'd0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 2'd3, 4'd4);
      applyStimulus(1'b0, 4'b1000, 1'b0, 2'd0, 4'd0);
      checkOutput("shrink_idle", 4'b0000, 2'd0, 1'b0);
      applyStimulus(1'b0, 4'b1000, 1'b0, 2'd0, 4'd0);
      checkOutput("shrink_c1", 4'b1000, 2'd3, 1'b0);
      applyStimulus(1'b0, 4'b1001, 1'b1, 2'd3, 4'd1);
      checkOutput("shrink_c2", 4'b1000, 2'd3, 1'b0);
      applyStimulus(1'b0, 4'b1001, 1'b0, 2'd0, 4'd0);
      checkOutput("shrink_c3", 4'b1000, 2'd3, 1'b1);
      applyStimulus(1'b0, 4'b1001, 1'b0, 2'd0, 4'd0);
      checkOutput("shrink_next", 4'b0001, 2'd0, 1'b0);

      // Reset mid-slice drops the grant at once and restores q[0] to 2.
      applyStimulus(1'b1, 4'b0000, 1'b0, 2'd0, 4'd0);
      applyStimulus(1'b0, 4'b0000, 1'b1, 2'd0, 4'd7);
      applyStimulus(1'b0, 4'b0001, 1'b0, 2'd0, 4'd0);
      applyStimulus(1'b0, 4'b0001, 1'b0, 2'd0, 4'd0);
      checkOutput("rst_busy", 4'b0001, 2'd0, 1'b0);
      applyStimulus(1'b1, 4'b0001, 1'b0, 2'd0, 4'd0);
      checkOutput("rst_async", 4'b0000, 2'd0, 1'b0);
      applyStimulus(1'b0, 4'b0001, 1'b0, 2'd0, 4'd0);
      checkOutput("rst_idle", 4'b0000, 2'd0, 1'b0);
      applyStimulus(1'b0, 4'b0001, 1'b0, 2'd0, 4'd0);
      checkOutput("rst_q_c1", 4'b0001, 2'd0, 1'b0);
      applyStimulus(1'b0, 4'b0001, 1'b0, 2'd0, 4'd0);
      checkOutput("rst_q_c2", 4'b0001, 2'd0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/weighted_rr_arbiter.md
WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

Interface
REQ-001 SHALL provide parameter: QW, 4, width of each quantum register and of the slice counter.
REQ-002 SHALL provide parameter: DEFAULT_Q, 2, reset value of every quantum register.
REQ-003 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port: REQ  input  4  request per requester; level-held while service is wanted.
REQ-006 SHALL provide port: CFG_WE  input  1  quantum write strobe, sampled on rising clk.
REQ-007 SHALL provide port: CFG_ADDR  input  2  requester index of quantum write.
REQ-008 SHALL provide port: CFG_Q  input  QW  quantum value, in grant cycles.
REQ-009 SHALL provide port: GNT  output  4  registered one-hot grant; all-zero when idle.
REQ-010 SHALL provide port: GNT_ID  output  2  index of current owner; 0 when idle.
REQ-011 SHALL provide port: GNT_VLD  output  1  high whenever GNT is non-zero.
REQ-012 SHALL provide port: SLICE_END  output  1  high in the final cycle of an owner's quantum.

Function
REQ-013 SHALL implement two states, IDLE and BUSY, plus registers owner[1:0], ptr[1:0], cnt[QW-1:0] and q[0..3][QW-1:0].
REQ-014 SHALL, in IDLE with REQ!=0, grant the first set REQ bit searching ptr, ptr+1, ... (mod 4); next cycle: BUSY, GNT one-hot, cnt=1.
REQ-015 SHALL, in IDLE with REQ==0, remain in IDLE with GNT=0.
REQ-016 SHALL treat effective quantum eq = max(q[owner],1); a stored value of 0 behaves as 1.
REQ-017 SHALL, in BUSY with REQ[owner]=1 and cnt<eq, keep owner and increment cnt.
REQ-018 SHALL, in BUSY with REQ[owner]=1 and cnt>=eq, grant the first other set bit searching owner+1, owner+2, owner+3; if none, keep owner and reload cnt=1.
REQ-019 SHALL, in BUSY with REQ[owner]=0, release immediately: next owner is the first set bit searching owner+1..owner+3 with cnt=1; if none, go to IDLE.
REQ-020 SHALL set ptr=old owner+1 (mod 4) on every owner change or release to IDLE.
REQ-021 SHALL give an uncontended requester exactly eq consecutive GNT cycles before any other requester is granted.
REQ-022 SHALL drive SLICE_END = BUSY & REQ[owner] & (cnt>=eq), as a function of registers and REQ only.
REQ-023 SHALL have a one-cycle request-to-grant latency from IDLE and zero dead cycles between successive owners.
REQ-024 SHALL write q[CFG_ADDR]=CFG_Q on a rising edge with CFG_WE=1; the new value takes effect on the following cycle's compare.
REQ-025 SHALL, when the owner's quantum is written below the current cnt, expire the slice at the next compare (>= rule).
REQ-026 SHALL saturate cnt at all-ones and never wrap.
REQ-027 SHALL apply the config write and the arbitration decision independently when both occur on the same edge.

Reset
REQ-028 SHALL, while rst=1 and asynchronously on its assertion, force: IDLE, GNT=0, GNT_ID=0, GNT_VLD=0, SLICE_END=0, ptr=0, cnt=0, all q=DEFAULT_Q.
REQ-029 SHALL, on reset during BUSY, drop the grant without completing the slice; after release, arbitration restarts from ptr=0.

Verification
REQ-030 SHALL cover: reset, REQ=0101 held -> GNT=0001 for 2 cycles, 0100 for 2 cycles, then 0001 again; SLICE_END high in each 2nd cycle.
REQ-031 SHALL cover: q[1]=5 written, REQ=0010 only -> GNT=0010 held continuously; cnt reloads after 5 cycles and SLICE_END pulses every 5th cycle.
REQ-032 SHALL cover: owner 0 with REQ=1001 and REQ[0] dropped after 1 grant cycle -> next cycle GNT=1000 with cnt=1, and ptr=1.
REQ-033 SHALL cover: q[2]=0 with REQ=0110 -> GNT alternates 0010 (2 cycles), 0100 (1 cycle).
REQ-034 SHALL cover: owner 3 at cnt=3 with q[3]=4, q[3] rewritten to 1 -> slice ends next cycle, and GNT passes to the next requester.
REQ-035 SHALL cover: rst pulsed mid-slice -> GNT=0 within the same cycle, and q values return to 2.
